// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states and frame constants for the UART receive path
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 8;
    localparam int DATA_BITS   = 8;
    localparam int DEFAULT_DIV = 325;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO with wrap-bit full/empty detection
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [7:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_pop, do_push;
    assign valid   = wptr != rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem[rptr[AW-1:0]] : 8'h00;
    // pointer advance; a pop frees the slot a same-cycle push takes when full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop) rptr <= rptr + ONE;
        end
    end
    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x oversampling 8N1 receiver; UART_RX_FIFO_EN selects FIFO vs single holding register
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int DIV        = DEFAULT_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       pop,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int TW = $clog2(DIV);
    rx_state_t state, state_n;
    logic sync1, sync2, rx_prev, start_det, tick;
    logic [TW-1:0] tick_cnt;
    logic [3:0] sub_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic shift_en, push, ferr_set, full, ovr_set;
    assign start_det = (state == IDLE) && rx_prev && !sync2;
    assign tick      = tick_cnt == TW'(DIV - 1);
    assign busy      = state != IDLE;
    assign ovr_set   = push && full && !pop;
    // two-flop synchronizer plus edge register, all idle-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end
    // oversample tick divider, realigned to the falling edge on start detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else tick_cnt <= (start_det || tick) ? '0 : tick_cnt + TW'(1);
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // next-state and per-cycle control strobes
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:  if (start_det) state_n = START;
            START: if (tick && sub_cnt == 4'(MID_SAMPLE - 1)) state_n = sync2 ? IDLE : DATA;
            DATA: begin
                if (tick && sub_cnt == 4'(OVERSAMPLE - 1)) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (tick && sub_cnt == 4'(OVERSAMPLE - 1)) begin
                    state_n  = IDLE;
                    push     = sync2;
                    ferr_set = !sync2;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // sub-tick and bit counters plus LSB-first shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE) begin
                sub_cnt <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                sub_cnt <= (state == START && sub_cnt == 4'(MID_SAMPLE - 1)) ? 4'd0 : sub_cnt + 4'd1;
            end
            if (shift_en) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end
    // sticky error flags; a set in the same cycle as clr_err wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set || (frame_err && !clr_err);
            overrun   <= ovr_set || (overrun && !clr_err);
        end
    end
`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (rdata),
        .valid (valid),
        .full  (full)
    );
`else
    logic [7:0] hold;
    logic hold_valid;
    assign full  = hold_valid;
    assign valid = hold_valid;
    assign rdata = hold_valid ? hold : 8'h00;
    // single holding register; a same-cycle pop makes room for the new byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (push && (!hold_valid || pop)) begin
            hold       <= shreg;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: frame-level stimulus checked against a byte-queue model of the receiver
module tb_uart_rx_unit;
    localparam int DIV     = 4;
    localparam int BIT_CYC = 16 * DIV;
    localparam int PUSH_C  = 3 + 152 * DIV;
    localparam int FRAME_C = 164 * DIV;
`ifdef UART_RX_FIFO_EN
    localparam int MODEL_DEPTH = 4;
`else
    localparam int MODEL_DEPTH = 1;
`endif
    logic clk = 1'b0;
    logic reset, rx, pop, clr_err;
    logic [7:0] rdata;
    logic valid, frame_err, overrun, busy;
    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic m_ferr, m_ovr;

    uart_rx_unit #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .pop       (pop),
        .clr_err   (clr_err),
        .rdata     (rdata),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":valid"}, valid, q.size() != 0);
        check({tag, ":rdata"}, rdata, q.size() != 0 ? q[0] : 8'h00);
        check({tag, ":frame_err"}, frame_err, m_ferr);
        check({tag, ":overrun"}, overrun, m_ovr);
        check({tag, ":busy"}, busy, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input bit stop, input bit pop_at, input bit clr_at, input int rst_at);
        int idx;
        for (int c = 0; c < FRAME_C; c++) begin
            idx = c / BIT_CYC;
            rx = idx == 0 ? 1'b0 : idx <= 8 ? b[idx-1] : idx == 9 ? stop : 1'b1;
            pop = pop_at && c == PUSH_C - 1;
            clr_err = clr_at && c == PUSH_C - 1;
            if (rst_at > 0) begin
                reset = c >= rst_at && c < rst_at + 5;
                if (c == rst_at) begin
                    q.delete();
                    m_ferr = 1'b0;
                    m_ovr = 1'b0;
                end
                if (c == rst_at + 2) check_state("in_reset");
            end
            @(posedge clk);
            #1;
        end
        pop = 1'b0;
        clr_err = 1'b0;
        reset = 1'b0;
        if (rst_at == 0) begin
            if (clr_at) begin
                m_ferr = 1'b0;
                m_ovr = 1'b0;
            end
            if (pop_at && q.size() != 0) void'(q.pop_front());
            if (!stop) m_ferr = 1'b1;
            else if (q.size() < MODEL_DEPTH) q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic do_pop(input string tag);
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        pop = 1'b0;
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'h55, 1, 0, 0, 0);
        check_state("clean55");
        do_pop("pop55");
        send(8'hA3, 1, 0, 0, 0);
        check_state("cleanA3");
        do_pop("popA3");
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch:busy", busy, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_state("glitch");
        send(8'h3C, 0, 0, 0, 0);
        check_state("badstop");
        do_clr();
        check_state("clr");
        for (int i = 1; i <= 5; i++) send(8'(i), 1, 0, 0, 0);
        check_state("ovf");
        while (q.size() != 0) do_pop("ovf_drain");
        do_pop("pop_empty");
        do_clr();
        for (int i = 1; i <= 4; i++) send(8'(i), 1, 0, 0, 0);
        do_clr();
        send(8'h05, 1, 1, 0, 0);
        check_state("full_pop");
        while (q.size() != 0) do_pop("full_drain");
        send(8'h77, 1, 0, 0, 0);
        send(8'hFF, 1, 0, 0, 72 * DIV);
        check_state("after_reset");
        send(8'h12, 1, 0, 0, 0);
        check_state("post_reset12");
        do_pop("pop12");
        send(8'h3C, 0, 0, 1, 0);
        check_state("clr_vs_set");
        do_clr();
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 0);
            check_state("rand");
            repeat ($urandom_range(0, 2)) do_pop("rand_pop");
            if ($urandom_range(0, 3) == 0) begin
                do_clr();
                check_state("rand_clr");
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
